// File: rtl/serial_crc32_framer.sv
// Byte-stream to serial-bit framer: emits payload LSB first, then the
// inverted reflected CRC-32 (FCS), then a fixed idle gap between frames.
module serial_crc32_framer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       new_message,
  output logic       fcs_phase,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FCS   = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_sr_q, fcs_sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  fcs_cnt_q, fcs_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;

  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic new_message_q, new_message_d;
  logic fcs_phase_q, fcs_phase_d;
  logic frame_done_q, frame_done_d;
  logic busy_q, busy_d;

  logic        ready;
  logic        xfer;
  logic        fb;
  logic [31:0] crc_next;

  // Ready depends on registered state only, never on s_valid.
  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_WAIT) ||
            ((state_q == S_DATA) && (bit_cnt_q == 3'd7) && !last_q);
  end

  assign xfer = s_valid && ready;

  always_comb begin
    fb       = crc_q[0] ^ shreg_q[0];
    crc_next = (crc_q >> 1) ^ ({32{fb}} & POLY);
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    crc_d     = crc_q;
    fcs_sr_d  = fcs_sr_q;
    bit_cnt_d = bit_cnt_q;
    fcs_cnt_d = fcs_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shreg_d = s_data;
          last_d  = s_last;
          crc_d   = CRC_INIT;
          state_d = S_START;
        end
      end
      S_START: begin
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        crc_d     = crc_next;
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (last_q) begin
            fcs_sr_d  = ~crc_next;
            fcs_cnt_d = 5'd0;
            state_d   = S_FCS;
          end else if (s_valid) begin
            shreg_d = s_data;
            last_d  = s_last;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (xfer) begin
          shreg_d   = s_data;
          last_d    = s_last;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_FCS: begin
        fcs_sr_d  = fcs_sr_q >> 1;
        fcs_cnt_d = fcs_cnt_q + 5'd1;
        if (fcs_cnt_q == 5'd31) begin
          gap_cnt_d = 8'd0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 8'd0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up
  // with the state they describe.
  always_comb begin
    bit_valid_d   = (state_d == S_DATA) || (state_d == S_FCS);
    new_message_d = (state_d == S_START);
    fcs_phase_d   = (state_d == S_FCS);
    frame_done_d  = (state_q == S_FCS) && (state_d == S_GAP);
    busy_d        = (state_d != S_IDLE);
    bit_out_d     = 1'b0;
    if (state_d == S_DATA) begin
      bit_out_d = shreg_d[0];
    end else if (state_d == S_FCS) begin
      bit_out_d = fcs_sr_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      last_q        <= 1'b0;
      crc_q         <= CRC_INIT;
      fcs_sr_q      <= '0;
      bit_cnt_q     <= '0;
      fcs_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      new_message_q <= 1'b0;
      fcs_phase_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      last_q        <= last_d;
      crc_q         <= crc_d;
      fcs_sr_q      <= fcs_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      fcs_cnt_q     <= fcs_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      new_message_q <= new_message_d;
      fcs_phase_q   <= fcs_phase_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign s_ready     = ready;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign new_message = new_message_q;
  assign fcs_phase   = fcs_phase_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_crc32_framer.sv
// Scoreboard bench for serial_crc32_framer: frames are queued on issue
// and checked by an independent bit-level monitor.
module tb_serial_crc32_framer;

  localparam int GAP = 2;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, bit_out, bit_valid, new_message;
  logic       fcs_phase, frame_done, busy;

  serial_crc32_framer #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .new_message(new_message), .fcs_phase(fcs_phase),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: standard byte-wise reflected CRC-32 with final inversion.
  function automatic logic [31:0] crc32_ref(input byte unsigned d[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'd0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return ~c;
  endfunction

  int           exp_len_q[$];
  byte unsigned exp_byte_q[$];
  logic [31:0]  exp_fcs_q[$];
  int           exp_wait_q[$];

  // Downstream CRC generator, enabled on payload bits only.
  logic [31:0] gen;
  always @(posedge clk or posedge rst) begin
    if (rst) gen <= 32'hFFFFFFFF;
    else if (new_message) gen <= 32'hFFFFFFFF;
    else if (bit_valid && !fcs_phase)
      gen <= (gen >> 1) ^ ((gen[0] ^ bit_out) ? POLY : 32'h0);
  end

  bit          in_frame = 0, in_gap = 0, have_done = 0;
  int          cyc_g = 0, done_cyc = 0;
  int          f_cyc, last_cyc, wait_cyc, nm_cnt, overlap;
  int          good_ready, bad_ready, gap_len, gap_ready;
  logic        bits[$];
  logic [31:0] fcs_v;
  int          fcs_n;

  task automatic close_frame();
    int len, w, bad;
    logic [31:0] fe;
    logic [7:0] eb, gb;
    if (exp_len_q.size() == 0) begin
      chk("frame_done_without_frame", 1, 0);
      return;
    end
    len = exp_len_q.pop_front();
    fe  = exp_fcs_q.pop_front();
    w   = exp_wait_q.pop_front();
    bad = 0;
    for (int i = 0; i < len; i++) begin
      eb = exp_byte_q.pop_front();
      gb = '0;
      for (int k = 0; k < 8; k++)
        if (8 * i + k < bits.size()) gb[k] = bits[8 * i + k];
      if (gb !== eb) bad++;
    end
    chk("payload_bit_count", bits.size(), 8 * len);
    chk("payload_bytes_bad", bad, 0);
    chk("fcs_value", fcs_v, fe);
    chk("fcs_bit_count", fcs_n, 32);
    chk("frame_cycles", last_cyc, 1 + 8 * len + 32 + w);
    chk("wait_cycles", wait_cyc, w);
    chk("new_message_count", nm_cnt, 1);
    chk("valid_with_new_message", overlap, 0);
    chk("s_ready_payload_cycles", good_ready, len - 1 + w);
    chk("s_ready_outside_payload", bad_ready, 0);
  endtask

  initial forever begin
    @(negedge clk);
    cyc_g++;
    if (rst) begin
      in_frame  = 0;
      in_gap    = 0;
      have_done = 0;
    end else begin
      if (new_message) begin
        if (in_frame) nm_cnt++;
        else begin
          if (have_done)
            chk("gap_before_new_message",
                32'(cyc_g - done_cyc >= GAP + 1), 1);
          have_done = 0;
          in_frame = 1;
          f_cyc = 0; last_cyc = 0; wait_cyc = 0; nm_cnt = 1;
          overlap = 0; good_ready = 0; bad_ready = 0;
          bits.delete(); fcs_v = '0; fcs_n = 0;
        end
      end
      if (in_frame) begin
        f_cyc++;
        if (bit_valid && new_message) overlap++;
        if (bit_valid && !fcs_phase) begin
          bits.push_back(bit_out);
          last_cyc = f_cyc;
        end
        if (bit_valid && fcs_phase) begin
          if (fcs_n == 0) begin
            if (exp_fcs_q.size() > 0)
              chk("downstream_crc_out", ~gen, exp_fcs_q[0]);
            else
              chk("downstream_no_expected_frame", 1, 0);
          end
          if (fcs_n < 32) fcs_v[fcs_n] = bit_out;
          fcs_n++;
          last_cyc = f_cyc;
        end
        if (!bit_valid && !new_message && fcs_n == 0 && bits.size() > 0)
          wait_cyc++;
        if (s_ready) begin
          if (!new_message && fcs_n == 0) good_ready++;
          else bad_ready++;
        end
        if (frame_done) begin
          close_frame();
          in_frame = 0;
          in_gap = 1; gap_len = 0; gap_ready = 0;
          have_done = 1; done_cyc = cyc_g;
        end
      end else if (frame_done) begin
        chk("frame_done_outside_frame", 1, 0);
      end
      if (in_gap) begin
        if (busy) begin
          gap_len++;
          if (s_ready) gap_ready++;
        end else begin
          chk("gap_length", gap_len, GAP);
          chk("gap_s_ready_high", gap_ready, 0);
          in_gap = 0;
        end
      end
    end
  end

  byte unsigned fb[$];
  int           st[$];

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    s_data = b; s_last = l; s_valid = 1'b1;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("s_ready_within_bound", s_ready, 1);
    @(negedge clk);
  endtask

  task automatic do_stall(input int k);
    int t;
    t = 0;
    s_valid = 1'b0;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("stall_sync_s_ready", s_ready, 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] fcs);
    int w;
    w = 0;
    foreach (st[i]) if (i > 0) w += st[i];
    exp_len_q.push_back(fb.size());
    foreach (fb[i]) exp_byte_q.push_back(fb[i]);
    exp_fcs_q.push_back(fcs);
    exp_wait_q.push_back(w);
    foreach (fb[i]) begin
      if (i > 0 && st[i] > 0) do_stall(st[i]);
      send_byte(fb[i], i == fb.size() - 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic set_check_string();
    fb.delete(); st.delete();
    for (int i = 0; i < 9; i++) begin
      fb.push_back(8'(8'h31 + i));
      st.push_back(0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, t;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {26'd0, bit_out, bit_valid, new_message, fcs_phase, frame_done, busy}, 0);
    rst = 1'b0;
    #1;
    chk("s_ready_after_reset", s_ready, 1);
    chk("busy_after_reset", busy, 0);
    @(negedge clk);

    // Two single zero-byte frames offered back to back.
    for (int r = 0; r < 2; r++) begin
      fb.delete(); st.delete();
      fb.push_back(8'h00); st.push_back(0);
      issue(32'hD202EF8D);
    end

    set_check_string();
    issue(32'hCBF43926);

    set_check_string();
    st[3] = 5;
    issue(32'hCBF43926);

    // Abort a 9-byte frame at payload bit 20.
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_bit_valid", bit_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {26'd0, bit_out, bit_valid, new_message, fcs_phase, frame_done, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s_ready_after_abort", s_ready, 1);
    @(negedge clk);
    fb.delete(); st.delete();
    fb.push_back(8'h00); st.push_back(0);
    issue(32'hD202EF8D);

    for (int f = 0; f < 25; f++) begin
      fb.delete(); st.delete();
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        fb.push_back(8'($urandom));
        st.push_back(($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4)));
      end
      issue(crc32_ref(fb));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    t = 0;
    while ((exp_len_q.size() != 0 || in_gap) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("all_frames_completed", exp_len_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
